// File: rtl/vga_sync_out.sv
// vga_sync_out
//   Raster timing generator and registered VGA output stage. Counts the
//   640x480@60 raster from the pixel clock and publishes the current
//   coordinate to the object drawers. Delays blanking and sync by PIPE_DELAY
//   clocks so they line up with the colour returned by the drawer/mux
//   pipeline, then registers everything onto the DAC and sync pins.
//
// Ports
//   clk                  pixel clock
//   resetN               asynchronous, active-low reset
//   redIn/greenIn/blueIn colour from the object mux, PIPE_DELAY clocks
//                        behind pixelX/pixelY
//   pixelX, pixelY       raw horizontal/vertical counters (also in blanking)
//   frameTick            one-clock strobe while (pixelX,pixelY) = (0,V_ACTIVE)
//   VGA_HS, VGA_VS       active-low syncs
//   VGA_BLANK_N          high while the displayed pixel is visible
//   VGA_R/G/B            DAC colour, zero while blanked
module vga_sync_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  redIn,
  input  logic [7:0]  greenIn,
  input  logic [7:0]  blueIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        frameTick,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
  localparam logic [10:0] V_VIS_LAST = 11'(V_ACTIVE - 1);
  localparam logic [10:0] HS_BEG     = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG     = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic [7:0] blank_colour(input logic vis, input logic [7:0] c);
    return vis ? c : 8'd0;
  endfunction

  logic [10:0] hCnt;
  logic [10:0] vCnt;

  // Stage p0: raster counters and combinational timing decode
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hCnt      <= '0;
      vCnt      <= '0;
      frameTick <= 1'b0;
    end else begin
      // Registered so the strobe is high exactly while the counters read
      // (0, V_ACTIVE): decode the clock that precedes it.
      frameTick <= (hCnt == H_LAST) && (vCnt == V_VIS_LAST);
      if (hCnt == H_LAST) begin
        hCnt <= '0;
        vCnt <= (vCnt == V_LAST) ? 11'd0 : vCnt + 11'd1;
      end else begin
        hCnt <= hCnt + 11'd1;
      end
    end
  end

  assign pixelX = hCnt;
  assign pixelY = vCnt;

  logic act_p0;
  logic hs_p0;
  logic vs_p0;

  always_comb begin
    act_p0 = (hCnt < H_VIS) && (vCnt < V_VIS);
    hs_p0  = !((hCnt >= HS_BEG) && (hCnt < HS_END));
    vs_p0  = !((vCnt >= VS_BEG) && (vCnt < VS_END));
  end

  // Stage p1..pN: delay line matching the drawer/mux latency
  logic act_pn;
  logic hs_pn;
  logic vs_pn;

  generate
    if (PIPE_DELAY == 0) begin : g_bypass
      assign act_pn = act_p0;
      assign hs_pn  = hs_p0;
      assign vs_pn  = vs_p0;
    end else begin : g_dly
      logic [PIPE_DELAY-1:0] act_sr;
      logic [PIPE_DELAY-1:0] hs_sr;
      logic [PIPE_DELAY-1:0] vs_sr;

      // Stages reset to the blanked, sync-inactive state so the outputs
      // stay quiet until the line refills after reset.
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          act_sr <= '0;
          hs_sr  <= '1;
          vs_sr  <= '1;
        end else begin
          act_sr[0] <= act_p0;
          hs_sr[0]  <= hs_p0;
          vs_sr[0]  <= vs_p0;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            act_sr[i] <= act_sr[i-1];
            hs_sr[i]  <= hs_sr[i-1];
            vs_sr[i]  <= vs_sr[i-1];
          end
        end
      end

      assign act_pn = act_sr[PIPE_DELAY-1];
      assign hs_pn  = hs_sr[PIPE_DELAY-1];
      assign vs_pn  = vs_sr[PIPE_DELAY-1];
    end
  endgenerate

  // Output stage: sync, blank and colour of one pixel leave on the same edge
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= 8'd0;
      VGA_G       <= 8'd0;
      VGA_B       <= 8'd0;
    end else begin
      VGA_HS      <= hs_pn;
      VGA_VS      <= vs_pn;
      VGA_BLANK_N <= act_pn;
      VGA_R       <= blank_colour(act_pn, redIn);
      VGA_G       <= blank_colour(act_pn, greenIn);
      VGA_B       <= blank_colour(act_pn, blueIn);
    end
  end

endmodule
